// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential unsigned restoring divider. One quotient bit is resolved per
//   clock, so a division takes WIDTH iterations plus one result cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        request, accepted while idle or in the done cycle
//   dividend     unsigned dividend, captured when start is accepted
//   divisor      unsigned divisor, captured when start is accepted
//   busy         high while iterations are running
//   done         one-cycle pulse, results valid from this cycle on
//   quotient     result quotient (all ones on divide by zero)
//   remainder    result remainder (dividend on divide by zero)
//   div_by_zero  set with done when the captured divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             last_iter;
    logic [CNT_W-1:0] cnt;

    // Captured operands and working registers
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] dvd;
    logic             dbz;
    logic [WIDTH-1:0] qreg;
    // The partial remainder is always below the divisor once stored, so its
    // top bit is zero; only the low WIDTH bits are kept, the extra bit lives
    // in the trial subtraction.
    logic [WIDTH-1:0] prem;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] prem_nxt;
    logic [WIDTH-1:0] qreg_nxt;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; the done cycle accepts a new start like idle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    // One restoring step: bring in the next dividend bit, try to subtract
    always_comb begin
        shifted = {prem, qreg[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            prem_nxt = trial[WIDTH-1:0];
            qreg_nxt = {qreg[WIDTH-2:0], 1'b1};
        end else begin
            prem_nxt = shifted[WIDTH-1:0];
            qreg_nxt = {qreg[WIDTH-2:0], 1'b0};
        end
    end

    // Iteration counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                quotient    <= dbz ? '1  : qreg_nxt;
                remainder   <= dbz ? dvd : prem_nxt;
                div_by_zero <= dbz;
            end
        end
    end

    // Operand capture and shift registers
    always_ff @(posedge clk) begin
        if (accept) begin
            dvsr <= divisor;
            dvd  <= dividend;
            dbz  <= (divisor == '0);
            qreg <= dividend;
            prem <= '0;
        end else if (state == BUSY) begin
            qreg <= qreg_nxt;
            prem <= prem_nxt;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    typedef struct {
        int q;
        int r;
        int z;
        int c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;

    // WIDTH=4 instance
    logic       start4;
    logic [3:0] dvd4, dvs4;
    logic       busy4, done4;
    logic [3:0] quo4, rem4;
    logic       dbz4;

    // WIDTH=2 instance
    logic       start2;
    logic [1:0] dvd2, dvs2;
    logic       busy2, done2;
    logic [1:0] quo2, rem2;
    logic       dbz2;

    int checks = 0;
    int passes = 0;
    int ndone4 = 0;
    int ndone2 = 0;
    exp_t q4[$];
    exp_t q2[$];
    exp_t e4, e2;

    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .quotient(quo4), .remainder(rem4),
        .div_by_zero(dbz4)
    );

    seq_divider #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .dividend(dvd2), .divisor(dvs2),
        .busy(busy2), .done(done2), .quotient(quo2), .remainder(rem2),
        .div_by_zero(dbz2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitors: pop the scoreboard whenever a done pulse is presented
    always @(negedge clk) begin
        if (done4) begin
            ndone4++;
            if (q4.size() == 0) begin
                chk("w4_pending_results", q4.size(), 1);
            end else begin
                e4 = q4.pop_front();
                chk("w4_quotient", quo4, e4.q);
                chk("w4_remainder", rem4, e4.r);
                chk("w4_div_by_zero", dbz4, e4.z);
                chk("w4_latency", cyc, e4.c);
                chk("w4_busy_in_done", busy4, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            ndone2++;
            if (q2.size() == 0) begin
                chk("w2_pending_results", q2.size(), 1);
            end else begin
                e2 = q2.pop_front();
                chk("w2_quotient", quo2, e2.q);
                chk("w2_remainder", rem2, e2.r);
                chk("w2_div_by_zero", dbz2, e2.z);
                chk("w2_latency", cyc, e2.c);
            end
        end
    end

    // Drive one start pulse; returns #1 after the accepting edge
    task automatic issue4(input int a, input int b, input int eq, input int er,
                          input int ez, input bit push);
        @(posedge clk);
        #1;
        start4 = 1'b1;
        dvd4   = 4'(a);
        dvs4   = 4'(b);
        if (push) q4.push_back('{eq, er, ez, cyc + 1 + 4});
        @(posedge clk);
        #1;
        start4 = 1'b0;
    endtask

    task automatic issue2(input int a, input int b, input int eq, input int er,
                          input int ez);
        @(posedge clk);
        #1;
        start2 = 1'b1;
        dvd2   = 2'(a);
        dvs2   = 2'(b);
        q2.push_back('{eq, er, ez, cyc + 1 + 2});
        @(posedge clk);
        #1;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input bit w2);
        int target;
        target = (w2 ? ndone2 : ndone4) + 1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            if ((w2 ? ndone2 : ndone4) >= target) return;
        end
        chk(w2 ? "w2_done_timeout" : "w4_done_timeout", w2 ? ndone2 : ndone4, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst    = 1'b1;
        start4 = 1'b0; dvd4 = '0; dvs4 = '0;
        start2 = 1'b0; dvd2 = '0; dvs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_quotient", quo4, 0);
        chk("rst_remainder", rem4, 0);
        chk("rst_div_by_zero", dbz4, 0);
        chk("rst_w2_busy", busy2, 0);

        // 13/3 with busy profile
        issue4(13, 3, 4, 1, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w4_busy_phase", busy4, 1);
            chk("w4_no_early_done", done4, 0);
        end
        wait_done(1'b0);

        // divide by zero, then divisor 1 clears the flag
        issue4(7, 0, 15, 7, 1, 1'b1);
        wait_done(1'b0);
        issue4(15, 1, 15, 0, 0, 1'b1);
        wait_done(1'b0);

        // dividend < divisor, zero dividend
        issue4(2, 5, 0, 2, 0, 1'b1);
        wait_done(1'b0);
        issue4(0, 9, 0, 0, 0, 1'b1);
        wait_done(1'b0);

        // start during busy is ignored
        issue4(12, 4, 3, 0, 0, 1'b1);
        @(posedge clk);
        #1;
        start4 = 1'b1; dvd4 = 4'd9; dvs4 = 4'd2;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done(1'b0);
        repeat (8) @(posedge clk);

        // back-to-back: start held through the done cycle
        issue4(11, 2, 5, 1, 0, 1'b1);
        k = cyc;
        @(posedge clk);
        #1;
        start4 = 1'b1; dvd4 = 4'd9; dvs4 = 4'd2;
        q4.push_back('{4, 1, 0, k + 9});
        repeat (4) @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done(1'b0);

        // reset in the second busy cycle aborts without a done
        issue4(14, 3, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_quotient", quo4, 0);
        chk("abort_remainder", rem4, 0);
        chk("abort_div_by_zero", dbz4, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // WIDTH=2 exhaustive sweep
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                if (b == 0) issue2(a, b, 3, a, 1);
                else        issue2(a, b, a / b, a % b, 0);
                wait_done(1'b1);
            end
        end

        repeat (4) @(posedge clk);
        chk("w4_results_drained", q4.size(), 0);
        chk("w2_results_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
